dffx_stim_gen: RTL

//  Upstream stimulus stage for a bank of WIDTH instrumented flip-flops: drives per-flop violation (V),

---
 rtl/dffx_stim_pkg.sv | 25 ++
 rtl/dffx_stim_if.sv | 30 +++
 rtl/dffx_stim_lfsr.sv | 38 +++
 rtl/dffx_stim_gen.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/dffx_stim_pkg.sv
// Shared types and constants for the dffx stimulus generator.
// State enum, LFSR taps/width, draw rotate step, rV tap offset.
package dffx_stim_pkg;

  localparam int          LFSR_W    = 32;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam int          ROT_STEP  = 5;
  localparam int          RV_OFS    = 11;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    RUN
  } state_e;

  function automatic logic [LFSR_W-1:0] rotr(
    input logic [LFSR_W-1:0] x,
    input int unsigned       k
  );
    logic [2*LFSR_W-1:0] t;
    t = {x, x} >> k;
    return t[LFSR_W-1:0];
  endfunction

endpackage

// File: rtl/dffx_stim_if.sv
// Control/monitor bundle for dffx_stim_gen.
// master: drives enable/seed_load/seed/rate/d_mon; slave: drives V/rD/rV/inject_count/busy.
interface dffx_stim_if #(
  parameter int WIDTH  = 8,
  parameter int RATE_W = 8,
  parameter int CNT_W  = 16
) ();

  logic              enable;
  logic              seed_load;
  logic [31:0]       seed;
  logic [RATE_W-1:0] rate;
  logic [WIDTH-1:0]  d_mon;
  logic [WIDTH-1:0]  V;
  logic [WIDTH-1:0]  rD;
  logic [WIDTH-1:0]  rV;
  logic [CNT_W-1:0]  inject_count;
  logic              busy;

  modport master (
    output enable, seed_load, seed, rate, d_mon,
    input  V, rD, rV, inject_count, busy
  );

  modport slave (
    input  enable, seed_load, seed, rate, d_mon,
    output V, rD, rV, inject_count, busy
  );

endinterface

// File: rtl/dffx_stim_lfsr.sv
// Seedable 32-bit Galois LFSR; a zero seed is replaced by 1.
// Ports: clk_i, rst_ni, step_i, load_i, seed_i, lfsr_o.
module dffx_stim_lfsr
  import dffx_stim_pkg::*;
#(
  parameter logic [31:0] RST_VAL = 32'hACE1_2468
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              step_i,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  localparam logic [LFSR_W-1:0] RST_NZ =
    (RST_VAL == '0) ? 32'h1 : RST_VAL;

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? 32'h1 : seed_i;
    end else if (step_i) begin
      lfsr_d = (lfsr_q >> 1)
             ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= RST_NZ;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/dffx_stim_gen.sv
// Violation / random-data stimulus for a bank of instrumented flops.
// Ports: CK, RS (async low), stim (dffx_stim_if.slave). Option: DFFX_STIM_HOLDOFF_EN.
module dffx_stim_gen
  import dffx_stim_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int          RATE_W   = 8,
  parameter logic [31:0] SEED_RST = 32'hACE1_2468,
  parameter int          CNT_W    = 16
`ifdef DFFX_STIM_HOLDOFF_EN
  , parameter int        HOLDOFF  = 4
`endif
) (
  input logic        CK,
  input logic        RS,
  dffx_stim_if.slave stim
);

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr;
  logic [WIDTH-1:0]  d_prev_q;
  logic [WIDTH-1:0]  v_q, v_d;
  logic [WIDTH-1:0]  rd_q, rd_d;
  logic [WIDTH-1:0]  rv_q, rv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q;
  logic              run;
  logic [WIDTH-1:0]  draw_ok;
  logic [LFSR_W-1:0] rot;
  logic [5:0]        pop;
  logic [CNT_W+5:0]  sum;

  localparam logic [CNT_W+5:0] CNT_MAX =
    {6'd0, {CNT_W{1'b1}}};

  // seed_load outranks enable from every state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, SEED, RUN:
        state_d = stim.enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if (stim.seed_load) state_d = SEED;
  end

  assign run = (state_q == RUN) && !stim.seed_load;

  dffx_stim_lfsr #(
    .RST_VAL (SEED_RST)
  ) u_lfsr (
    .clk_i  (CK),
    .rst_ni (RS),
    .step_i (run),
    .load_i (stim.seed_load),
    .seed_i (stim.seed),
    .lfsr_o (lfsr)
  );

  always_comb begin
    draw_ok = '0;
    rot     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rot = rotr(lfsr, (ROT_STEP * i) % LFSR_W);
      draw_ok[i] = rot[RATE_W-1:0] < stim.rate;
    end
  end

`ifdef DFFX_STIM_HOLDOFF_EN
  localparam int HW = $clog2(HOLDOFF + 1);
  logic [HW-1:0]    hold_q [WIDTH];
  logic [HW-1:0]    hold_d [WIDTH];
  logic [WIDTH-1:0] hold_ok;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      hold_ok[i] = (hold_q[i] == '0);
    end
  end
`endif

  always_comb begin
    v_d  = '0;
    rd_d = rd_q;
    rv_d = rv_q;
    if (run) begin
`ifdef DFFX_STIM_HOLDOFF_EN
      v_d = (stim.d_mon ^ d_prev_q) & draw_ok & hold_ok;
`else
      v_d = (stim.d_mon ^ d_prev_q) & draw_ok;
`endif
      for (int i = 0; i < WIDTH; i++) begin
        rd_d[i] = lfsr[i % LFSR_W];
        rv_d[i] = lfsr[(i + RV_OFS) % LFSR_W];
      end
    end
  end

`ifdef DFFX_STIM_HOLDOFF_EN
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      hold_d[i] = hold_q[i];
      if (stim.seed_load)      hold_d[i] = '0;
      else if (v_d[i])         hold_d[i] = HW'(HOLDOFF);
      else if (hold_q[i] != 0) hold_d[i] = hold_q[i] - 1'b1;
    end
  end

  always_ff @(posedge CK or negedge RS) begin
    if (!RS) begin
      for (int i = 0; i < WIDTH; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) hold_q[i] <= hold_d[i];
    end
  end
`endif

  // count is fed by the already-registered V
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + 6'(v_q[i]);
    end
    sum   = {6'd0, cnt_q} + {{CNT_W{1'b0}}, pop};
    cnt_d = (sum > CNT_MAX) ? {CNT_W{1'b1}}
                            : sum[CNT_W-1:0];
  end

  always_ff @(posedge CK or negedge RS) begin
    if (!RS) begin
      state_q  <= IDLE;
      d_prev_q <= '0;
      v_q      <= '0;
      rd_q     <= '0;
      rv_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      d_prev_q <= stim.d_mon;
      v_q      <= v_d;
      rd_q     <= rd_d;
      rv_q     <= rv_d;
      cnt_q    <= cnt_d;
      busy_q   <= (state_d == RUN);
    end
  end

  assign stim.V            = v_q;
  assign stim.rD           = rd_q;
  assign stim.rV           = rv_q;
  assign stim.inject_count = cnt_q;
  assign stim.busy         = busy_q;

endmodule
